// File: rtl/execute_pkg.sv
// Shared op-code constants and the multi-cycle FSM state type for the execute stage.
package execute_pkg;

    localparam logic [4:0] OP_ADD     = 5'h00;
    localparam logic [4:0] OP_SUB     = 5'h01;
    localparam logic [4:0] OP_AND     = 5'h02;
    localparam logic [4:0] OP_OR      = 5'h03;
    localparam logic [4:0] OP_XOR     = 5'h04;
    localparam logic [4:0] OP_SHL     = 5'h05;
    localparam logic [4:0] OP_SHR     = 5'h06;
    localparam logic [4:0] OP_SRA     = 5'h07;
    localparam logic [4:0] OP_GTU     = 5'h08;
    localparam logic [4:0] OP_GTS     = 5'h09;
    localparam logic [4:0] OP_EQ      = 5'h0A;
    localparam logic [4:0] OP_CORENUM = 5'h0B;
    localparam logic [4:0] OP_MUL     = 5'h10;
    localparam logic [4:0] OP_MULHU   = 5'h11;
    localparam logic [4:0] OP_DIVU    = 5'h12;
    localparam logic [4:0] OP_REMU    = 5'h13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/execute_muldiv.sv
// Iterative unsigned multiplier / restoring divider: one step per BUSY cycle, XLEN steps per op.
// op_i[1] selects divide, op_i[0] selects the high half (MULHU) or remainder (REMU).
module execute_muldiv
    import execute_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            ack_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [1:0]      state_o
);
    localparam int CNT_W = $clog2(XLEN);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       op_q;
    logic [XLEN-1:0]  hi_q, lo_q, b_q;
    logic [XLEN:0]    mul_sum, div_sh, div_diff;
    logic             div_ge;

    // Multiply: {hi,lo} shifts right, adding b into hi when the lsb of the multiplier is set.
    // Divide: hi is the partial remainder, lo shifts the dividend out and the quotient in.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_sh   = {hi_q, lo_q[XLEN-1]};
        div_ge   = div_sh >= {1'b0, b_q};
        div_diff = div_sh - {1'b0, b_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    state_q <= BUSY;
                    cnt_q   <= CNT_W'(XLEN - 1);
                    op_q    <= op_i;
                    hi_q    <= '0;
                    lo_q    <= a_i;
                    b_q     <= b_i;
                end
                BUSY: begin
                    if (op_q[1]) begin
                        hi_q <= div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
                        lo_q <= {lo_q[XLEN-2:0], div_ge};
                    end else begin
                        hi_q <= mul_sum[XLEN:1];
                        lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
                    end
                    if (cnt_q == '0) state_q <= DONE;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                DONE: if (ack_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Divide by zero falls out naturally: every step subtracts 0, so quotient is all-ones
    // and the remainder ends up equal to the dividend.
    assign busy_o   = (state_q == BUSY);
    assign done_o   = (state_q == DONE);
    assign result_o = op_q[0] ? hi_q : lo_q;
    assign state_o  = state_q;

endmodule

// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU, jump/memory address generation, registered result.
// Define EXECUTE_UNIT_MULDIV_EN to add the iterative MUL/MULHU/DIVU/REMU unit (else those ops yield 0).
module execute_unit
    import execute_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_W  = 4,
    parameter int CORE_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CORE_W-1:0] corenum,
    input  logic [XLEN-1:0]   pc,
    input  logic              stall_in,
    output logic              stall,
    input  logic [REG_W-1:0]  dest,
    input  logic [4:0]        aluop,
    input  logic [XLEN-1:0]   reg_a,
    input  logic [XLEN-1:0]   reg_b,
    input  logic [XLEN-1:0]   reg_m,
    input  logic              is_mem_in,
    input  logic              mem_write_in,
    input  logic              is_jump,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_addr,
    output logic [XLEN-1:0]   fwd_val,
    output logic              jump,
    output logic [XLEN-1:0]   jump_addr,
    output logic [REG_W-1:0]  out_addr,
    output logic [XLEN-1:0]   out_val,
    output logic              is_mem,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_val,
    output logic              mem_write
);
    localparam int SH_W = $clog2(XLEN);

    logic [4:0]       op;
    logic [SH_W-1:0]  shamt;
    logic [XLEN-1:0]  sum_ab, result;
    logic             wb_mem;
    logic [REG_W-1:0] wb_addr;
    logic [XLEN-1:0]  wb_val;

    assign op     = is_jump ? OP_ADD : aluop;
    assign shamt  = reg_b[SH_W-1:0];
    assign sum_ab = reg_a + reg_b;

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:     result = is_jump ? pc + XLEN'(4) : sum_ab;
            OP_SUB:     result = reg_a - reg_b;
            OP_AND:     result = reg_a & reg_b;
            OP_OR:      result = reg_a | reg_b;
            OP_XOR:     result = reg_a ^ reg_b;
            OP_SHL:     result = reg_a << shamt;
            OP_SHR:     result = reg_a >> shamt;
            OP_SRA:     result = $signed(reg_a) >>> shamt;
            OP_GTU:     result = {{(XLEN-1){1'b0}}, reg_a > reg_b};
            OP_GTS:     result = {{(XLEN-1){1'b0}}, $signed(reg_a) > $signed(reg_b)};
            OP_EQ:      result = {{(XLEN-1){1'b0}}, reg_a == reg_b};
            OP_CORENUM: result = {{(XLEN-CORE_W){1'b0}}, corenum};
            default:    result = '0;
        endcase
    end

    assign jump      = is_jump;
    assign jump_addr = sum_ab;
    assign mem_addr  = sum_ab;
    assign mem_val   = reg_m;
    assign mem_write = mem_write_in;

`ifdef EXECUTE_UNIT_MULDIV_EN
    logic             md_issue, md_start, md_busy, md_done;
    logic [1:0]       md_state;
    logic [XLEN-1:0]  md_result;
    logic [REG_W-1:0] md_dest_q;

    // While DONE the upstream still presents the finished op, so only IDLE may issue.
    assign md_issue = (md_state == IDLE) && (aluop[4:2] == 3'b100) && !is_jump;
    assign md_start = md_issue && !stall_in;
    assign stall    = md_issue || md_busy || stall_in;

    execute_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (md_start),
        .ack_i    (!stall_in),
        .op_i     (aluop[1:0]),
        .a_i      (reg_a),
        .b_i      (reg_b),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .result_o (md_result),
        .state_o  (md_state)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        md_dest_q <= '0;
        else if (md_start) md_dest_q <= dest;
    end

    always_comb begin
        fwd_valid = ~is_mem_in;
        fwd_addr  = dest;
        fwd_val   = result;
        if (md_done) begin
            fwd_valid = 1'b1;
            fwd_addr  = md_dest_q;
            fwd_val   = md_result;
        end else if (md_issue || md_busy) begin
            fwd_valid = 1'b0;
        end
    end

    assign wb_addr = md_done ? md_dest_q : dest;
    assign wb_val  = md_done ? md_result : result;
    assign wb_mem  = md_done ? 1'b0 : is_mem_in;
`else
    assign stall     = stall_in;
    assign fwd_valid = ~is_mem_in;
    assign fwd_addr  = dest;
    assign fwd_val   = result;
    assign wb_addr   = dest;
    assign wb_val    = result;
    assign wb_mem    = is_mem_in;
`endif

    // Downstream stall holds everything; a self-generated stall writes a bubble (out_val kept).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_addr <= '0;
            out_val  <= '0;
            is_mem   <= 1'b0;
        end else if (!stall_in) begin
            if (stall) begin
                out_addr <= '0;
                is_mem   <= 1'b0;
            end else begin
                out_addr <= wb_addr;
                out_val  <= wb_val;
                is_mem   <= wb_mem;
            end
        end
    end

endmodule

// File: tb/tb_execute_unit.sv
// Scoreboard bench for execute_unit; covers the mul/div path when EXECUTE_UNIT_MULDIV_EN is defined.
module tb_execute_unit;
    import execute_pkg::*;

    localparam int XLEN   = 32;
    localparam int REG_W  = 4;
    localparam int CORE_W = 5;
    localparam int EW     = 1 + REG_W + XLEN;

    logic              clk, rst_n;
    logic [CORE_W-1:0] corenum;
    logic [XLEN-1:0]   pc;
    logic              stall_in, stall;
    logic [REG_W-1:0]  dest;
    logic [4:0]        aluop;
    logic [XLEN-1:0]   reg_a, reg_b, reg_m;
    logic              is_mem_in, mem_write_in, is_jump;
    logic              fwd_valid;
    logic [REG_W-1:0]  fwd_addr;
    logic [XLEN-1:0]   fwd_val;
    logic              jump;
    logic [XLEN-1:0]   jump_addr;
    logic [REG_W-1:0]  out_addr;
    logic [XLEN-1:0]   out_val;
    logic              is_mem;
    logic [XLEN-1:0]   mem_addr, mem_val;
    logic              mem_write;

    execute_unit #(.XLEN(XLEN), .REG_W(REG_W), .CORE_W(CORE_W)) dut (
        .clk(clk), .rst_n(rst_n), .corenum(corenum), .pc(pc),
        .stall_in(stall_in), .stall(stall), .dest(dest), .aluop(aluop),
        .reg_a(reg_a), .reg_b(reg_b), .reg_m(reg_m),
        .is_mem_in(is_mem_in), .mem_write_in(mem_write_in), .is_jump(is_jump),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_val(fwd_val),
        .jump(jump), .jump_addr(jump_addr),
        .out_addr(out_addr), .out_val(out_val), .is_mem(is_mem),
        .mem_addr(mem_addr), .mem_val(mem_val), .mem_write(mem_write)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_chk  = 0;
    int n_pass = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // Reference model
    function automatic logic [XLEN-1:0] model(input logic [4:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [XLEN-1:0] ones, msb;
        logic [63:0]     prod;
        int              sh;
        ones = '1;
        msb  = {1'b1, {(XLEN-1){1'b0}}};
        sh   = int'(b % XLEN);
        prod = 64'(a) * 64'(b);
        case (op)
            5'h00: return a + b;
            5'h01: return a - b;
            5'h02: return a & b;
            5'h03: return a | b;
            5'h04: return a ^ b;
            5'h05: return a << sh;
            5'h06: return a >> sh;
            5'h07: return (a >> sh) | (a[XLEN-1] ? ~(ones >> sh) : '0);
            5'h08: return (a > b) ? 1 : 0;
            5'h09: return ((a ^ msb) > (b ^ msb)) ? 1 : 0;
            5'h0A: return (a == b) ? 1 : 0;
            5'h0B: return XLEN'(corenum);
`ifdef EXECUTE_UNIT_MULDIV_EN
            5'h10: return prod[XLEN-1:0];
            5'h11: return prod[2*XLEN-1:XLEN];
            5'h12: return (b == 0) ? ones : a / b;
            5'h13: return (b == 0) ? a : a % b;
`endif
            default: return '0;
        endcase
    endfunction

    // Driver tasks
    task automatic drive_idle();
        aluop = 5'h00; dest = '0; reg_a = '0; reg_b = '0; reg_m = '0;
        is_mem_in = 1'b0; mem_write_in = 1'b0; is_jump = 1'b0; stall_in = 1'b0;
    endtask

    logic [REG_W-1:0] last_addr;
    logic [XLEN-1:0]  last_val;

    task automatic check_out();
        logic [EW-1:0] e;
        check("sb_depth", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_addr", 64'(out_addr), 64'(e[XLEN+REG_W-1:XLEN]));
            check("out_val", 64'(out_val), 64'(e[XLEN-1:0]));
            check("is_mem", 64'(is_mem), 64'(e[EW-1]));
            last_addr = e[XLEN+REG_W-1:XLEN];
            last_val  = e[XLEN-1:0];
        end
    endtask

    // Call shortly after a rising edge; returns shortly after the capturing edge.
    task automatic issue(input logic [4:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [REG_W-1:0] d, input logic mem, input logic jmp);
        logic [XLEN-1:0] e, s;
        aluop = op; reg_a = a; reg_b = b; dest = d; is_mem_in = mem; is_jump = jmp;
        reg_m = a ^ b; mem_write_in = mem & b[0]; stall_in = 1'b0;
        e = jmp ? pc + 32'd4 : model(op, a, b);
        s = a + b;
        exp_q.push_back({mem, d, e});
        @(negedge clk);
        check("fwd_valid", 64'(fwd_valid), 64'(!mem));
        check("fwd_addr", 64'(fwd_addr), 64'(d));
        check("fwd_val", 64'(fwd_val), 64'(e));
        check("stall_single", 64'(stall), 64'd0);
        check("mem_addr", 64'(mem_addr), 64'(s));
        check("jump_addr", 64'(jump_addr), 64'(s));
        check("jump", 64'(jump), 64'(jmp));
        check("mem_val", 64'(mem_val), 64'(a ^ b));
        check("mem_write", 64'(mem_write), 64'(mem & b[0]));
        @(posedge clk); #1;
        check_out();
    endtask

`ifdef EXECUTE_UNIT_MULDIV_EN
    // hold > 0 raises stall_in from BUSY on and keeps it high for hold DONE cycles.
    task automatic issue_multi(input logic [4:0] op, input logic [XLEN-1:0] a,
                               input logic [XLEN-1:0] b, input logic [REG_W-1:0] d, input int hold);
        logic [XLEN-1:0] e;
        int n_stall, edges, bad;
        aluop = op; reg_a = a; reg_b = b; dest = d; is_mem_in = 1'b0; is_jump = 1'b0;
        stall_in = 1'b0;
        e = model(op, a, b);
        exp_q.push_back({1'b0, d, e});
        n_stall = 0; edges = 0; bad = 0;
        @(negedge clk);
        check("issue_fwd_valid", 64'(fwd_valid), 64'd0);
        while (!fwd_valid && edges < 4 * XLEN) begin
            if (stall) n_stall++;
            @(posedge clk); #1;
            edges++;
            if (hold > 0) stall_in = 1'b1;
            if (out_addr != '0 || is_mem) bad++;
            @(negedge clk);
        end
        check("stall_cycles", 64'(n_stall), 64'(XLEN + 1));
        check("done_edges", 64'(edges), 64'(XLEN + 1));
        check("bubble_out", 64'(bad), 64'd0);
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            if (fwd_val != e || !fwd_valid || !stall) bad++;
            @(posedge clk); #1;
            if (out_addr != '0) bad++;
            @(negedge clk);
        end
        check("done_hold", 64'(bad), 64'd0);
        stall_in = 1'b0;
        #1;
        check("done_fwd_valid", 64'(fwd_valid), 64'd1);
        check("done_fwd_addr", 64'(fwd_addr), 64'(d));
        check("done_fwd_val", 64'(fwd_val), 64'(e));
        check("done_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        check_out();
    endtask
`endif

    initial begin
        logic [4:0] op;
        rst_n = 1'b0; corenum = 5'd3; pc = 32'h100;
        last_addr = '0; last_val = '0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_addr", 64'(out_addr), 64'd0);
        check("rst_out_val", 64'(out_val), 64'd0);
        check("rst_is_mem", 64'(is_mem), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(OP_SUB, 32'd5, 32'd7, 4'd1, 1'b0, 1'b0);
        issue(OP_ADD, 32'h2000, 32'h10, 4'd2, 1'b0, 1'b1);
        issue(OP_CORENUM, 32'h55, 32'h66, 4'd3, 1'b0, 1'b0);
        issue(OP_SRA, 32'h8000_0000, 32'd36, 4'd4, 1'b0, 1'b0);
        issue(OP_SHL, 32'h0000_00F1, 32'd31, 4'd5, 1'b0, 1'b0);
        issue(OP_GTS, 32'hFFFF_FFFF, 32'd1, 4'd6, 1'b0, 1'b0);
        issue(OP_GTU, 32'hFFFF_FFFF, 32'd1, 4'd7, 1'b0, 1'b0);
        issue(OP_EQ, 32'h1234, 32'h1234, 4'd8, 1'b0, 1'b0);
        issue(OP_ADD, 32'hFFFF_FFFF, 32'd2, 4'd9, 1'b1, 1'b0);
        issue(5'h0D, 32'h1234, 32'h1234, 4'd10, 1'b0, 1'b0);
        issue(5'h1F, 32'h1234, 32'h1234, 4'd11, 1'b0, 1'b0);
`ifndef EXECUTE_UNIT_MULDIV_EN
        for (int i = 0; i < 4; i++)
            issue(OP_MUL + 5'(i), 32'd100, 32'd7, 4'(12 + i), 1'b0, 1'b0);
`endif

        // Downstream stall on a single-cycle op: outputs hold, stall mirrors stall_in
        aluop = OP_OR; reg_a = 32'hF0; reg_b = 32'h0F; dest = 4'd14; stall_in = 1'b1;
        @(negedge clk);
        check("stall_in_pass", 64'(stall), 64'd1);
        @(posedge clk); #1;
        check("hold_addr", 64'(out_addr), 64'(last_addr));
        check("hold_val", 64'(out_val), 64'(last_val));
        issue(OP_OR, 32'hF0, 32'h0F, 4'd14, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op = 5'($urandom_range(0, 31));
`ifdef EXECUTE_UNIT_MULDIV_EN
            if (op[4:2] == 3'b100) op = OP_XOR;
`endif
            pc = 32'($urandom) & 32'hFFFF_FFFC;
            corenum = 5'($urandom_range(0, 31));
            issue(op, 32'($urandom), (i % 3 == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'(i % 7 == 0));
        end
        corenum = 5'd3; pc = 32'h100;

`ifdef EXECUTE_UNIT_MULDIV_EN
        issue_multi(OP_MUL, 32'h10000, 32'h10000, 4'd3, 0);
        issue_multi(OP_MULHU, 32'h10000, 32'h10000, 4'd4, 0);
        issue_multi(OP_DIVU, 32'd100, 32'd0, 4'd5, 0);
        issue_multi(OP_REMU, 32'd100, 32'd0, 4'd6, 0);
        issue_multi(OP_DIVU, 32'd100, 32'd7, 4'd7, 5);
        issue(OP_ADD, 32'd1, 32'd2, 4'd8, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            issue_multi(OP_MUL + 5'(i), 32'($urandom), 32'($urandom_range(1, 32'hFFFF)), 4'(9 + i), 0);
`endif

        // Asynchronous reset in the middle of operation
        issue(OP_ADD, 32'd7, 32'd8, 4'd9, 1'b0, 1'b0);
`ifdef EXECUTE_UNIT_MULDIV_EN
        aluop = OP_MUL; reg_a = 32'd3; reg_b = 32'd5; dest = 4'd6;
        repeat (6) @(posedge clk);
`endif
        @(negedge clk);
        drive_idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_addr", 64'(out_addr), 64'd0);
        check("arst_out_val", 64'(out_val), 64'd0);
        check("arst_is_mem", 64'(is_mem), 64'd0);
        check("arst_stall", 64'(stall), 64'd0);
        @(negedge clk);
        aluop = OP_XOR; reg_a = 32'hA5A5; reg_b = 32'h0FF0; dest = 4'd9;
        exp_q.push_back({1'b0, 4'd9, 32'hA5A5 ^ 32'h0FF0});
        rst_n = 1'b1;
        #1;
        check("rel_stall", 64'(stall), 64'd0);
        check("rel_fwd_valid", 64'(fwd_valid), 64'd1);
        @(posedge clk); #1;
        check_out();
        issue(OP_AND, 32'hFF00, 32'h0FF0, 4'd10, 1'b0, 1'b0);

        drive_idle();
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
